// File: rtl/mem_responder_if.sv
// Load/store request bus between the exec stage (master) and memory (slave).
// Carries req/we/addr/wdata/width out, rdata/ready/busy back.
interface mem_responder_if #(
  parameter int M_WIDTH = 32
);
  logic               mem_req;
  logic               mem_we;
  logic [M_WIDTH-1:0] mem_addr;
  logic [M_WIDTH-1:0] mem_wdata;
  logic [1:0]         mem_acc_width;
  logic [M_WIDTH-1:0] mem_rdata;
  logic               mem_ready;
  logic               busy;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_acc_width,
    input  mem_rdata, mem_ready, busy
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_acc_width,
    output mem_rdata, mem_ready, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one byte per WAIT_CYCLES clocks, little-endian, 4-phase req/ready.
// Ports: clk, rst_n (async, active low), bus (mem_responder_if.slave).
module mem_responder #(
  parameter int M_WIDTH     = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  mem_responder_if.slave   bus
);
  localparam logic [1:0] MEM_ACC_8  = 2'b00;
  localparam logic [1:0] MEM_ACC_16 = 2'b01;
  localparam logic [1:0] MEM_ACC_32 = 2'b10;

  localparam int AW  = $clog2(DEPTH);
  localparam int NB  = M_WIDTH / 8;
  localparam int BW  = $clog2(NB + 1);
  localparam int WCW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic               we_q, we_d;
  logic [M_WIDTH-1:0] wdata_q, wdata_d;
  logic [BW-1:0]      n_q, n_d;
  logic [BW-1:0]      idx_q, idx_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic [M_WIDTH-1:0] acc_q, acc_d;
  logic [M_WIDTH-1:0] rdata_q, rdata_d;
  logic               ready_q, ready_d;

  logic [7:0]         mem [0:DEPTH-1];
  logic [AW-1:0]      byte_addr;
  logic [7:0]         rd_byte;
  logic [M_WIDTH-1:0] wsh;
  logic [7:0]         wr_byte;
  logic               wr_en;
  logic [BW-1:0]      n_req;
  int                 nb_raw;

  logic               unused_addr;
  assign unused_addr = ^bus.mem_addr[M_WIDTH-1:AW];

  assign byte_addr = a_q + AW'(idx_q);
  assign rd_byte   = mem[byte_addr];
  assign wsh       = wdata_q >> {idx_q, 3'b000};
  assign wr_byte   = wsh[7:0];

  always_comb begin
    nb_raw = 0;
    unique case (1'b1)
      (bus.mem_acc_width == MEM_ACC_8):  nb_raw = 1;
      (bus.mem_acc_width == MEM_ACC_16): nb_raw = 2;
      (bus.mem_acc_width == MEM_ACC_32): nb_raw = 4;
      default:                           nb_raw = 0;
    endcase
    n_req = BW'((nb_raw > NB) ? NB : nb_raw);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    n_d     = n_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          a_d     = bus.mem_addr[AW-1:0];
          we_d    = bus.mem_we;
          wdata_d = bus.mem_wdata;
          n_d     = n_req;
          acc_d   = '0;
          idx_d   = '0;
          wcnt_d  = '0;
          if (n_req == '0) begin
            rdata_d = '0;
            state_d = DONE;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (wcnt_q == WCW'(WAIT_CYCLES - 1)) begin
          wcnt_d = '0;
          idx_d  = idx_q + 1'b1;
          if (we_q) begin
            wr_en = 1'b1;
          end else begin
            acc_d = acc_q |
              (M_WIDTH'(rd_byte) << {idx_q, 3'b000});
          end
          if (idx_q == BW'(n_q - 1'b1)) begin
            rdata_d = we_q ? '0 : acc_d;
            ready_d = 1'b1;
            state_d = DONE;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      DONE: begin
        // Illegal-width requests arrive with ready low;
        // raise it once so every request sees a pulse.
        if (!ready_q) begin
          ready_d = 1'b1;
        end else if (!bus.mem_req) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[byte_addr] <= wr_byte;
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table on a 1-wait instance,
// plus handshake, abort, 3-wait and mid-access reset sequences.
module tb_mem_responder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_responder_if #(.M_WIDTH(32)) ia ();
  mem_responder_if #(.M_WIDTH(32)) ib ();

  mem_responder #(
    .M_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );

  mem_responder #(
    .M_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic req,
                       input logic we, input logic [1:0] w,
                       input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (sel == 0) begin
      ia.mem_req = req; ia.mem_we = we;
      ia.mem_acc_width = w; ia.mem_addr = addr;
      ia.mem_wdata = wdata;
    end else begin
      ib.mem_req = req; ib.mem_we = we;
      ib.mem_acc_width = w; ib.mem_addr = addr;
      ib.mem_wdata = wdata;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ia.mem_ready : ib.mem_ready;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel == 0) ? ia.busy : ib.busy;
  endfunction

  function automatic logic [31:0] rdat(input int sel);
    return (sel == 0) ? ia.mem_rdata : ib.mem_rdata;
  endfunction

  task automatic set_req(input int sel, input logic req);
    if (sel == 0) ia.mem_req = req;
    else          ib.mem_req = req;
  endtask

  // Called #1 after an edge; returns edges from accept to ready.
  task automatic wait_ready(input int sel, output int lat);
    lat = 0;
    while (!rdy(sel) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rdy(sel)) begin
      errors++;
      $display("FAIL timeout: ready never rose on dut %0d", sel);
    end
  endtask

  task automatic xact(input int sel, input string nm,
                      input logic we, input logic [1:0] w,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic [31:0] exp_rd,
                      input int exp_lat);
    int lat;
    drive(sel, 1'b1, we, w, addr, wdata);
    @(posedge clk); #1;
    chk({nm, " busy"}, {31'd0, bsy(sel)}, 32'd1);
    wait_ready(sel, lat);
    chk({nm, " lat"}, lat, exp_lat);
    chk({nm, " rdata"}, rdat(sel), exp_rd);
    set_req(sel, 1'b0);
    @(posedge clk); #1;
    chk({nm, " ready_low"}, {31'd0, rdy(sel)}, 32'd0);
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    tbl[0]  = '{1'b1, 2'b10, 32'h10,  32'hDEADBEEF, 32'h0,        4};
    tbl[1]  = '{1'b0, 2'b10, 32'h10,  32'h0,        32'hDEADBEEF, 4};
    tbl[2]  = '{1'b0, 2'b00, 32'h13,  32'h0,        32'h000000DE, 1};
    tbl[3]  = '{1'b0, 2'b01, 32'h11,  32'h0,        32'h0000ADBE, 2};
    tbl[4]  = '{1'b1, 2'b10, 32'hFE,  32'h11223344, 32'h0,        4};
    tbl[5]  = '{1'b0, 2'b10, 32'hFE,  32'h0,        32'h11223344, 4};
    tbl[6]  = '{1'b0, 2'b00, 32'hFE,  32'h0,        32'h00000044, 1};
    tbl[7]  = '{1'b0, 2'b00, 32'hFF,  32'h0,        32'h00000033, 1};
    tbl[8]  = '{1'b0, 2'b00, 32'h00,  32'h0,        32'h00000022, 1};
    tbl[9]  = '{1'b0, 2'b00, 32'h01,  32'h0,        32'h00000011, 1};
    tbl[10] = '{1'b1, 2'b11, 32'h10,  32'hFFFFFFFF, 32'h0,        1};
    tbl[11] = '{1'b0, 2'b10, 32'h10,  32'h0,        32'hDEADBEEF, 4};
    tbl[12] = '{1'b1, 2'b10, 32'h20,  32'h01020304, 32'h0,        4};
    tbl[13] = '{1'b1, 2'b01, 32'h20,  32'hBEEFCAFE, 32'h0,        2};
    tbl[14] = '{1'b0, 2'b10, 32'h20,  32'h0,        32'h0102CAFE, 4};
    tbl[15] = '{1'b0, 2'b00, 32'h113, 32'h0,        32'h000000DE, 1};

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", {31'd0, ia.mem_ready}, 32'd0);
    chk("rst busy", {31'd0, ia.busy}, 32'd0);
    chk("rst rdata", ia.mem_rdata, 32'h0);
    chk("rst b ready", {31'd0, ib.mem_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      xact(0, $sformatf("vec%0d", i), tbl[i].we, tbl[i].w,
           tbl[i].addr, tbl[i].wdata,
           tbl[i].exp_rd, tbl[i].exp_lat);
    end

    // Hold req 5 extra cycles after ready.
    drive(0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    @(posedge clk); #1;
    wait_ready(0, lat);
    chk("hold lat", lat, 4);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold ready", {31'd0, ia.mem_ready}, 32'd1);
      chk("hold rdata", ia.mem_rdata, 32'hDEADBEEF);
      chk("hold busy", {31'd0, ia.busy}, 32'd1);
    end
    ia.mem_req = 1'b0;
    @(posedge clk); #1;
    chk("hold drop", {31'd0, ia.mem_ready}, 32'd0);
    chk("hold idle", {31'd0, ia.busy}, 32'd0);

    // Drop req right after accept; access still completes.
    drive(0, 1'b1, 1'b0, 2'b10, 32'hFE, 32'h0);
    @(posedge clk); #1;
    ia.mem_req = 1'b0;
    wait_ready(0, lat);
    chk("abort lat", lat, 4);
    chk("abort rdata", ia.mem_rdata, 32'h11223344);
    @(posedge clk); #1;
    chk("abort pulse", {31'd0, ia.mem_ready}, 32'd0);
    chk("abort idle", {31'd0, ia.busy}, 32'd0);

    // Three clocks per byte.
    xact(1, "w3 st16", 1'b1, 2'b01, 32'h40, 32'h0000BEEF,
         32'h0, 6);
    xact(1, "w3 ld16", 1'b0, 2'b01, 32'h40, 32'h0,
         32'h0000BEEF, 6);
    xact(1, "w3 ill", 1'b0, 2'b11, 32'h40, 32'h0,
         32'h0, 1);
    xact(1, "w3 ld8", 1'b0, 2'b00, 32'h41, 32'h0,
         32'h000000BE, 3);

    // Reset after the second byte of a store lands.
    drive(0, 1'b1, 1'b1, 2'b10, 32'h10, 32'hCAFEF00D);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid busy", {31'd0, ia.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst ready", {31'd0, ia.mem_ready}, 32'd0);
    chk("arst busy", {31'd0, ia.busy}, 32'd0);
    chk("arst rdata", ia.mem_rdata, 32'h0);
    ia.mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(0, "post rst", 1'b0, 2'b10, 32'h10, 32'h0,
         32'hDEADF00D, 4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
